// File: rtl/mmc5_snd_seq.sv
// mmc5_snd_seq: MMC5 audio control. 240 Hz frame sequencer, $5010/$5011/$5015 registers,
// PCM capture in read mode and PCM IRQ. All state advances on the falling edge of m2.
module mmc5_snd_seq #(
    parameter logic [14:0] FRAME_LAST = 15'd29829,
    parameter logic [14:0] STEP1      = 15'd7457,
    parameter logic [14:0] STEP2      = 15'd14912,
    parameter logic [14:0] STEP3      = 15'd22370,
    parameter logic [14:0] STEP4      = 15'd29828
) (
    input  logic        m2,
    input  logic        map_rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dat,
    input  logic        cpu_rw,
    input  logic        cpu_ce,
    input  logic [1:0]  l_ctr_nz,
    output logic        e_clk,
    output logic        l_clk,
    output logic [1:0]  ch_en,
    output logic [7:0]  pcm,
    output logic        irq,
    output logic [7:0]  dout,
    output logic        dout_oe
);
    logic [14:0] frame_ctr;
    logic        pcm_mode, irq_en, irq_pend;
    logic        rd, wr, hit_5010, hit_5011, hit_5015, pcm_fetch, dat_nz, q_step, h_step;

    assign rd        = cpu_ce & cpu_rw;
    assign wr        = cpu_ce & ~cpu_rw;
    assign hit_5010  = cpu_addr == 16'h5010;
    assign hit_5011  = cpu_addr == 16'h5011;
    assign hit_5015  = cpu_addr == 16'h5015;
    assign dat_nz    = |cpu_dat;
    assign pcm_fetch = rd & pcm_mode & (cpu_addr[15:14] == 2'b10);
    assign q_step    = (frame_ctr == STEP1) | (frame_ctr == STEP3);
    assign h_step    = (frame_ctr == STEP2) | (frame_ctr == STEP4);
    assign irq       = irq_pend & irq_en;

    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            frame_ctr <= '0;
            e_clk     <= 1'b0;
            l_clk     <= 1'b0;
        end else begin
            frame_ctr <= (frame_ctr == FRAME_LAST) ? 15'd0 : frame_ctr + 15'd1;
            e_clk     <= q_step | h_step;
            l_clk     <= h_step;
        end
    end

    // a zero sample in read mode means end of stream: hold the level and flag the IRQ
    always_ff @(negedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            pcm_mode <= 1'b0;
            irq_en   <= 1'b0;
            irq_pend <= 1'b0;
            ch_en    <= 2'b00;
            pcm      <= 8'h00;
        end else begin
            if (wr & hit_5010) begin
                pcm_mode <= cpu_dat[0];
                irq_en   <= cpu_dat[7];
            end
            if (wr & hit_5015)
                ch_en <= cpu_dat[1:0];
            if (dat_nz & ((wr & hit_5011 & ~pcm_mode) | pcm_fetch))
                pcm <= cpu_dat;
            if (pcm_fetch & ~dat_nz)
                irq_pend <= 1'b1;
            else if (rd & hit_5010)
                irq_pend <= 1'b0;
        end
    end

    always_comb begin
        dout_oe = rd & (hit_5010 | hit_5015);
        dout    = (rd & hit_5010) ? {irq, 6'b0, pcm_mode} :
                  (rd & hit_5015) ? {6'b0, l_ctr_nz} : 8'h00;
    end
endmodule

// File: tb/tb_mmc5_snd_seq.sv
// tb_mmc5_snd_seq: randomized and directed checks of mmc5_snd_seq against a behavioural
// model of the register file and a modular-arithmetic model of the frame strobes.
module tb_mmc5_snd_seq;
    localparam int P = 29830;
    localparam int S1 = 7457, S2 = 14912, S3 = 22370, S4 = 29828;

    logic        m2, map_rst_n, cpu_rw, cpu_ce;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dat;
    logic [1:0]  l_ctr_nz;
    logic        e_clk, l_clk, irq, dout_oe;
    logic [1:0]  ch_en;
    logic [7:0]  pcm, dout;

    int n_cmp = 0, n_bad = 0;
    int n = 0;
    logic [7:0] m_pcm, last_dout;
    logic [1:0] m_ch;
    logic       m_mode, m_en, m_pend, last_oe;

    mmc5_snd_seq dut (
        .m2(m2), .map_rst_n(map_rst_n), .cpu_addr(cpu_addr), .cpu_dat(cpu_dat),
        .cpu_rw(cpu_rw), .cpu_ce(cpu_ce), .l_ctr_nz(l_ctr_nz), .e_clk(e_clk),
        .l_clk(l_clk), .ch_en(ch_en), .pcm(pcm), .irq(irq), .dout(dout), .dout_oe(dout_oe)
    );

    initial m2 = 1'b1;
    always #5 m2 = ~m2;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // falling edges since reset release equals the sequencer position modulo P
    always @(negedge m2 or negedge map_rst_n)
        if (!map_rst_n) n <= 0;
        else n <= n + 1;

    always @(posedge m2) begin : strobe_chk
        int p;
        if (map_rst_n) begin
            p = (n + P - 1) % P;
            check("strobe{e,l}", {e_clk, l_clk},
                  {p == S1 || p == S2 || p == S3 || p == S4, p == S2 || p == S4});
        end
    end

    task automatic model_reset();
        m_pcm = 0; m_ch = 0; m_mode = 0; m_en = 0; m_pend = 0;
    endtask

    task automatic op(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic ce);
        logic rd, wr, eoe;
        logic [7:0] ed;
        @(posedge m2);
        check("pcm", pcm, m_pcm);
        check("ch_en", ch_en, m_ch);
        check("irq", irq, m_pend & m_en);
        cpu_addr = a; cpu_dat = d; cpu_rw = rw; cpu_ce = ce;
        #1;
        rd = ce & rw;
        wr = ce & !rw;
        eoe = rd && (a == 16'h5010 || a == 16'h5015);
        ed = (rd && a == 16'h5010) ? {m_pend & m_en, 6'b0, m_mode} :
             (rd && a == 16'h5015) ? {6'b0, l_ctr_nz} : 8'h00;
        check("dout", dout, ed);
        check("dout_oe", dout_oe, eoe);
        last_dout = dout;
        last_oe = dout_oe;
        if (wr && a == 16'h5011 && !m_mode && d != 0) m_pcm = d;
        if (rd && m_mode && a >= 16'h8000 && a <= 16'hBFFF) begin
            if (d != 0) m_pcm = d;
            else m_pend = 1;
        end
        if (rd && a == 16'h5010) m_pend = 0;
        if (wr && a == 16'h5010) begin m_mode = d[0]; m_en = d[7]; end
        if (wr && a == 16'h5015) m_ch = d[1:0];
        @(negedge m2);
        #1 cpu_ce = 1'b0;
    endtask

    initial begin
        int ne, nl, waited;
        logic [15:0] a;
        logic [7:0] d;
        map_rst_n = 0; cpu_addr = 0; cpu_dat = 0; cpu_rw = 1; cpu_ce = 0; l_ctr_nz = 0;
        model_reset();
        repeat (2) @(posedge m2);
        #1;
        check("rst_outs", {e_clk, l_clk, ch_en, pcm, irq, dout, dout_oe}, 0);
        @(posedge m2);
        map_rst_n = 1;
        ne = 0; nl = 0;
        repeat (2 * P) begin
            @(posedge m2);
            #1;
            ne += int'(e_clk);
            nl += int'(l_clk);
        end
        check("e_count_2frames", 16'(ne), 16'd8);
        check("l_count_2frames", 16'(nl), 16'd4);

        op(16'h5011, 8'h80, 0, 1); check("t2_pcm80", pcm, 8'h80);
        op(16'h5011, 8'h00, 0, 1); check("t2_pcm_hold", pcm, 8'h80);
        op(16'h5015, 8'h02, 0, 1); check("t2_ch_en", ch_en, 2'b10);

        op(16'h5010, 8'h81, 0, 1);
        op(16'h9000, 8'h40, 1, 1); check("t3_pcm40", pcm, 8'h40); check("t3_irq0", irq, 0);
        op(16'hA000, 8'h00, 1, 1); check("t3_pcm_hold", pcm, 8'h40); check("t3_irq1", irq, 1);
        op(16'h5010, 8'hFF, 1, 1); check("t3_dout", last_dout, 8'h81); check("t3_ack", irq, 0);

        op(16'hA000, 8'h00, 1, 1);
        op(16'h5010, 8'h01, 0, 1); check("t4_masked", irq, 0);
        op(16'h5010, 8'h81, 0, 1); check("t4_unmasked", irq, 1);
        op(16'hC000, 8'h00, 1, 1); check("t4_c000_ignored", pcm, 8'h40);
        op(16'h5011, 8'h33, 0, 1); check("t4_rdmode_5011", pcm, 8'h40);

        l_ctr_nz = 2'b01;
        op(16'h5015, 8'h00, 1, 1); check("t5_dout", last_dout, 8'h01); check("t5_oe", last_oe, 1);
        op(16'h4015, 8'h00, 1, 1); check("t5_oe_4015", last_oe, 0);
        op(16'hD010, 8'h00, 0, 1); check("mirror_d010", irq, 1);

        repeat (400) begin
            case ($urandom_range(0, 7))
                0: a = 16'h5010;
                1: a = 16'h5011;
                2: a = 16'h5015;
                3: a = 16'hD010;
                4: a = 16'h4015;
                5: a = 16'hC000 | 16'($urandom_range(0, 16'h3FFF));
                default: a = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
            endcase
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            l_ctr_nz = 2'($urandom_range(0, 3));
            op(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
        end

        op(16'h5010, 8'h80, 0, 1);
        op(16'h5011, 8'h55, 0, 1);
        op(16'h5015, 8'h03, 0, 1);
        waited = 0;
        while (n % P != S2 && waited < P + 5) begin
            @(posedge m2);
            waited++;
        end
        check("reach_14912", 16'(n % P), 16'(S2));
        map_rst_n = 0;
        model_reset();
        #1;
        check("t6_rst_outs", {e_clk, l_clk, ch_en, pcm, irq, dout, dout_oe}, 0);
        repeat (3) @(posedge m2);
        #1;
        check("t6_no_l_clk", {e_clk, l_clk}, 0);
        @(posedge m2);
        map_rst_n = 1;
        waited = 0;
        do begin
            @(posedge m2);
            #1;
            waited++;
        end while (!e_clk && waited < 8000);
        check("t6_first_e", 16'(n), 16'd7458);
        op(16'h5010, 8'h00, 1, 1);
        check("t6_mode_reset", last_dout, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
